// File: rtl/datapath_mc.sv
// Multicycle RV32 datapath slice: inter-cycle registers, register file,
// immediate extender, ALU and muxes, all steered by an external controller.
module datapath_mc #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  PC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCWrite,
   input  logic            IRWrite,
   input  logic            RegWrite,
   input  logic            AdrSrc,
   input  logic [1:0]      ResultSrc,
   input  logic [1:0]      ALUSrcA,
   input  logic [1:0]      ALUSrcB,
   input  logic [2:0]      ImmSrc,
   input  logic [2:0]      ALUControl,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] mem_adr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [6:0]      op,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic            Zero,
   output logic            lt
);

   logic [XLEN-1:0] pc, old_pc, ir, data, a, b, alu_out;
   logic [XLEN-1:0] rf [32];
   logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
   logic [4:0]      rs1, rs2, rd;

   assign rs1   = ir[19:15];
   assign rs2   = ir[24:20];
   assign rd    = ir[11:7];
   assign op    = ir[6:0];
   assign func3 = ir[14:12];
   assign func7 = ir[31:25];

   // x0 is forced to zero on read; no bypass from the write port.
   assign rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
   assign rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];

   always_comb begin
      imm_ext = '0;
      case (ImmSrc)
         3'b000: imm_ext = {{20{ir[31]}}, ir[31:20]};
         3'b001: imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         3'b010: imm_ext = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         3'b011: imm_ext = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         3'b100: imm_ext = {ir[31:12], 12'b0};
         default: imm_ext = '0;
      endcase
   end

   always_comb begin
      src_a = '0;
      case (ALUSrcA)
         2'b00:   src_a = pc;
         2'b01:   src_a = old_pc;
         2'b10:   src_a = a;
         default: src_a = '0;
      endcase
      src_b = '0;
      case (ALUSrcB)
         2'b00:   src_b = b;
         2'b01:   src_b = imm_ext;
         2'b10:   src_b = XLEN'(4);
         default: src_b = '0;
      endcase
   end

   // True signed compare on the ALU inputs, independent of the operation.
   assign lt = $signed(src_a) < $signed(src_b);

   always_comb begin
      alu_result = '0;
      case (ALUControl)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b111:  alu_result = src_a ^ src_b;
         3'b100:  alu_result = src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, lt};
         default: alu_result = '0;
      endcase
   end

   assign Zero = (alu_result == '0);

   always_comb begin
      result = '0;
      case (ResultSrc)
         2'b00:   result = alu_out;
         2'b01:   result = data;
         2'b10:   result = alu_result;
         default: result = '0;
      endcase
   end

   assign mem_adr   = AdrSrc ? result : pc;
   assign mem_wdata = b;

   // OldPC captures the pre-edge PC even when PCWrite fires on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= PC_RESET;
         old_pc  <= '0;
         ir      <= '0;
         data    <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
      end else begin
         if (PCWrite) pc <= result;
         if (IRWrite) begin
            ir     <= mem_rdata;
            old_pc <= pc;
         end
         data    <= mem_rdata;
         a       <= rd1;
         b       <= rd2;
         alu_out <= alu_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (RegWrite && (rd != 5'd0)) begin
         rf[rd] <= result;
      end
   end

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Multicycle RV32 datapath slice driven directly by the multicycle controller. Holds the architectural and inter-cycle registers (PC, OldPC, IR, Data, A, B, ALUOut), the 32x32 register file, the immediate extender, the ALU and the source/result muxes. It returns `op`, `func3`, `func7`, `Zero` and `lt` to the controller. It presents address and write data to the external unified instruction/data memory.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `PC_RESET`, 32'h0: value PC takes on reset.

Ports:
- `clk`  in  1  system clock; all registers update on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PCWrite, IRWrite, RegWrite, AdrSrc`  in  1 each  controller strobes.
- `ResultSrc, ALUSrcA, ALUSrcB`  in  2 each  mux selects.
- `ImmSrc`  in  3  immediate format select.
- `ALUControl`  in  3  ALU operation select.
- `mem_rdata`  in  32  memory read data, combinational from `mem_adr`.
- `mem_adr`  out  32  memory byte address.
- `mem_wdata`  out  32  store data; equals register B.
- `op`  out  7  IR[6:0].
- `func3`  out  3  IR[14:12].
- `func7`  out  7  IR[31:25].
- `Zero`  out  1  ALUResult == 0.
- `lt`  out  1  signed SrcA < signed SrcB.

## Operation
- Mux encodings:
  - ALUSrcA: 00 PC, 01 OldPC, 10 A, 11 zero.
  - ALUSrcB: 00 B, 01 ImmExt, 10 constant 4, 11 zero.
  - ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult, 11 zero.
  - AdrSrc: 0 PC, 1 Result.
- ImmSrc encodings (all sign-extended from IR[31]):
  - 000 I: IR[31:20].
  - 001 S: {IR[31:25], IR[11:7]}.
  - 010 B: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - 011 J: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - 100 U: {IR[31:12], 12'b0}.
  - Other codes: 0.
- ALUControl encodings:
  - 000 add; 001 sub (A−B, two's complement wrap).
  - 010 and; 011 or; 111 xor.
  - 100 pass SrcB; 101 slt signed, giving 32'h1 or 32'h0.
  - 110 reserved, result 0.
- Registers:
  - PC <= Result when PCWrite.
  - IR <= mem_rdata and OldPC <= PC when IRWrite, both on the same edge.
  - Data <= mem_rdata every cycle.
  - A <= rf[IR[19:15]] and B <= rf[IR[24:20]] every cycle.
  - ALUOut <= ALUResult every cycle.
- Register file:
  - Two combinational read ports addressed from the current IR.
  - One write port: rf[IR[11:7]] <= Result on the edge when RegWrite.
  - Writes to x0 are discarded, and x0 always reads 0.
  - No write-to-read bypass. A read in the write cycle returns the old value, and A/B capture the new value one cycle later.
- `lt` is computed on the ALU inputs, independent of ALUControl. It is the true signed compare, with no overflow error from a subtract sign bit.
- Reset: PC = PC_RESET; OldPC, IR, Data, A, B, ALUOut and all 32 rf entries = 0.
  - Outputs after reset: op = 0, func3 = 0, func7 = 0.
  - mem_adr = PC_RESET when AdrSrc = 0; mem_wdata = 0.
  - Reset asserted mid-instruction discards all in-flight state immediately, without waiting for a clock.

## Timing
- All outputs are combinational from registers and inputs; zero added latency.
- Fetch cycle (AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1): at the edge, IR = mem[PC], OldPC = PC, PC = PC+4.
- Decode cycle: A/B load from the new IR; ALUOut = OldPC+ImmExt (branch/jal target).
- Load: address cycle sets ALUOut = A+imm. Next cycle mem_adr = ALUOut (AdrSrc=1, ResultSrc=00) and Data captures. Next cycle Result = Data is written to rd.
- Branch compare cycle: Zero/lt are valid combinationally in the same cycle. PCWrite with ResultSrc=00 loads PC from ALUOut.
- jal/jalr: PC <= ALUOut while the ALU forms OldPC+4 into ALUOut. rd is written on the following edge.
- PC wraps modulo 2^32 with no fault. Misaligned addresses are passed through unchanged.
- Simultaneous PCWrite and IRWrite: OldPC takes the pre-edge PC.

## Test plan
- Reset with PC_RESET = 32'h0 and rst asserted between edges. PC, IR and ALUOut must clear without a clock edge. mem_adr = 0 and op = 0.
- Fetch with mem[0] = 32'h00500093 (addi x1,x0,5), then drive the addi sequence. Required: PC = 4, OldPC = 0, op = 7'h13, and rf[1] = 5 after the writeback edge.
- lw x2,4(x1) with x1 = 8 and mem[12] = 32'hDEADBEEF. mem_adr = 12 in the memory cycle; rf[2] = 32'hDEADBEEF.
- beq with x1 = x3 = 7 and imm = −8 at OldPC = 16. Zero = 1 in the compare cycle, and PC = 8 after PCWrite. With x3 = 6: Zero = 0 and lt = 0.
- Signed compare with A = 32'h80000000 and B = 1. lt = 1 and slt result = 1. Under sub, the result wraps to 32'h7FFFFFFF.
- Write to x0 with RegWrite and rd = 0, Result = 32'h1234. Reading x0 afterwards returns 0. lui x5,0xABCDE yields rf[5] = 32'hABCDE000.
